// File: rtl/pll_reset_sequencer.sv
// PLL lock consumer: synchronises the asynchronous lock flag, holds the
// system reset until lock has been stable for a programmable number of
// cycles, re-asserts reset on lock loss and counts loss events.
`timescale 1ns/1ps
module pll_reset_sequencer #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1024,
    parameter int HOLD_CYCLES   = 16,
    parameter int LOSS_CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_locked,
    input  logic                  clear_sticky,
    output logic                  sys_reset,
    output logic                  sys_ready,
    output logic                  lock_lost_sticky,
    output logic [LOSS_CNT_W-1:0] lock_lost_count
);

    localparam int MAX_CYCLES = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [CNT_W-1:0]      STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]      HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [LOSS_CNT_W-1:0] COUNT_MAX   = {LOSS_CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_WAIT,
        ST_STABLE,
        ST_RUN,
        ST_HOLD
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       counter;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;

    // Metastability chain for the lock flag, followed by a retiming flop so
    // the FSM always consumes a clean registered level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q   <= '0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], pll_locked};
            locked_s <= sync_q[SYNC_STAGES-1];
        end
    end

    // Sequencing FSM; outputs are registered and updated on the same edge the
    // state enters or leaves RUN. A loss event overrides a same-cycle clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_WAIT;
            counter          <= '0;
            sys_reset        <= 1'b1;
            sys_ready        <= 1'b0;
            lock_lost_sticky <= 1'b0;
            lock_lost_count  <= '0;
        end else begin
            if (clear_sticky) begin
                lock_lost_sticky <= 1'b0;
            end
            case (state)
                ST_WAIT: begin
                    if (locked_s) begin
                        state   <= ST_STABLE;
                        counter <= '0;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state <= ST_WAIT;
                    end else if (counter == STABLE_LAST) begin
                        state     <= ST_RUN;
                        sys_reset <= 1'b0;
                        sys_ready <= 1'b1;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        state            <= ST_HOLD;
                        counter          <= '0;
                        sys_reset        <= 1'b1;
                        sys_ready        <= 1'b0;
                        lock_lost_sticky <= 1'b1;
                        if (lock_lost_count != COUNT_MAX) begin
                            lock_lost_count <= lock_lost_count + LOSS_CNT_W'(1);
                        end
                    end
                end
                ST_HOLD: begin
                    if (counter == HOLD_LAST) begin
                        state <= ST_WAIT;
                    end else begin
                        counter <= counter + CNT_W'(1);
                    end
                end
                default: begin
                    state     <= ST_WAIT;
                    sys_reset <= 1'b1;
                    sys_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short stable/hold times and a
// 2-bit loss counter so saturation is reachable.
`timescale 1ns/1ps
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES   = 2;
    localparam int STABLE_CYCLES = 8;
    localparam int HOLD_CYCLES   = 4;
    localparam int LOSS_CNT_W    = 2;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  pll_locked;
    logic                  clear_sticky;
    logic                  sys_reset;
    logic                  sys_ready;
    logic                  lock_lost_sticky;
    logic [LOSS_CNT_W-1:0] lock_lost_count;

    int errors = 0;
    int checks = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_CYCLES(STABLE_CYCLES),
        .HOLD_CYCLES  (HOLD_CYCLES),
        .LOSS_CNT_W   (LOSS_CNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .pll_locked      (pll_locked),
        .clear_sticky    (clear_sticky),
        .sys_reset       (sys_reset),
        .sys_ready       (sys_ready),
        .lock_lost_sticky(lock_lost_sticky),
        .lock_lost_count (lock_lost_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 ns past the last one
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Tick until sys_reset falls (bounded); returns edges taken
    task automatic wait_release(output int n);
        n = 0;
        while (sys_reset === 1'b1 && n < 60) begin
            tick(1);
            n++;
        end
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        pll_locked   = 1'b0;
        clear_sticky = 1'b0;
        tick(1);
        checks++;
        if (sys_reset !== 1'b1 || sys_ready !== 1'b0 || lock_lost_sticky !== 1'b0 || lock_lost_count !== 2'd0) begin
            errors++;
            $display("[TB] FAIL reset_values: got rst=%b rdy=%b sticky=%b cnt=%0d, want 1 0 0 0",
                     sys_reset, sys_ready, lock_lost_sticky, lock_lost_count);
        end
        reset = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick(1);
            checks++;
            if (sys_reset !== 1'b1 || sys_ready !== 1'b0 || lock_lost_count !== 2'd0) begin
                errors++;
                $display("[TB] FAIL unlocked_hold cycle %0d: got rst=%b rdy=%b cnt=%0d, want 1 0 0",
                         i, sys_reset, sys_ready, lock_lost_count);
            end
        end
    endtask

    task automatic test_release();
        int n;
        pll_locked = 1'b1;
        wait_release(n);
        checks++;
        if (n - 1 != 11) begin
            errors++;
            $display("[TB] FAIL release_latency: got %0d edges, want 11", n - 1);
        end
        checks++;
        if (sys_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL release_ready: got %b, want 1", sys_ready);
        end
    endtask

    task automatic test_glitch();
        int n;
        reset = 1'b1;
        pll_locked = 1'b0;
        tick(1);
        reset = 1'b0;
        tick(3);
        pll_locked = 1'b1;
        tick(5);
        pll_locked = 1'b0;
        tick(1);
        pll_locked = 1'b1;
        wait_release(n);
        checks++;
        if (n - 1 != 11) begin
            errors++;
            $display("[TB] FAIL glitch_relock_latency: got %0d edges, want 11", n - 1);
        end
        checks++;
        if (lock_lost_count !== 2'd0 || lock_lost_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL glitch_no_loss: got cnt=%0d sticky=%b, want 0 0",
                     lock_lost_count, lock_lost_sticky);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        pll_locked = 1'b0;
        tick(2);
        pll_locked = 1'b1;
        tick(1);
        checks++;
        if (sys_reset !== 1'b0) begin
            errors++;
            $display("[TB] FAIL loss_early: got sys_reset=%b at drop+2, want 0", sys_reset);
        end
        tick(1);
        checks++;
        if (sys_reset !== 1'b1 || sys_ready !== 1'b0 || lock_lost_count !== 2'd1 || lock_lost_sticky !== 1'b1) begin
            errors++;
            $display("[TB] FAIL loss_assert: got rst=%b rdy=%b cnt=%0d sticky=%b, want 1 0 1 1",
                     sys_reset, sys_ready, lock_lost_count, lock_lost_sticky);
        end
        wait_release(n);
        checks++;
        if (n != 13) begin
            errors++;
            $display("[TB] FAIL loss_rerelease: got %0d cycles from hold, want 13", n);
        end
    endtask

    task automatic test_saturation();
        int n;
        logic [1:0] exp_count [5];
        exp_count = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        wait_release(n);
        checks++;
        if (sys_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL sat_initial_run: got ready=%b, want 1", sys_ready);
        end
        for (int i = 0; i < 5; i++) begin
            pll_locked = 1'b0;
            tick(2);
            pll_locked = 1'b1;
            tick(1);
            if (i == 3) clear_sticky = 1'b1;
            tick(1);
            clear_sticky = 1'b0;
            checks++;
            if (lock_lost_count !== exp_count[i] || lock_lost_sticky !== 1'b1) begin
                errors++;
                $display("[TB] FAIL sat_loss %0d: got cnt=%0d sticky=%b, want %0d 1",
                         i, lock_lost_count, lock_lost_sticky, exp_count[i]);
            end
            wait_release(n);
            if (i == 2) begin
                clear_sticky = 1'b1;
                tick(1);
                clear_sticky = 1'b0;
                checks++;
                if (lock_lost_sticky !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL sticky_clear: got %b, want 0", lock_lost_sticky);
                end
            end
        end
    endtask

    task automatic test_reset_in_run();
        int n;
        checks++;
        if (sys_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL pre_reset_run: got ready=%b, want 1", sys_ready);
        end
        reset = 1'b1;
        tick(1);
        checks++;
        if (sys_reset !== 1'b1 || sys_ready !== 1'b0 || lock_lost_count !== 2'd0 || lock_lost_sticky !== 1'b0) begin
            errors++;
            $display("[TB] FAIL run_reset: got rst=%b rdy=%b cnt=%0d sticky=%b, want 1 0 0 0",
                     sys_reset, sys_ready, lock_lost_count, lock_lost_sticky);
        end
        reset = 1'b0;
        wait_release(n);
        checks++;
        if (n - 1 != 11) begin
            errors++;
            $display("[TB] FAIL run_reset_rerelease: got %0d edges, want 11", n - 1);
        end
    endtask

    // Run the scenarios in order and report
    initial begin
        test_reset();
        test_release();
        test_glitch();
        test_lock_loss();
        test_saturation();
        test_reset_in_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
